// File: rtl/cam_capture_rx.sv
// Camera parallel-port receiver: registers HREF/VSYNC/data, pairs bytes (high first) into
// 16-bit pixels with X/Y coordinates and frame markers. Optional 2x2 decimation: CAM_CAPTURE_DECIM_EN.
module cam_capture_rx #(
  parameter int XW    = 11,
  parameter int YW    = 10,
  parameter int MAX_W = 640,
  parameter int MAX_H = 512
) (
  input  logic          PCLK,
  input  logic          RST_N,
  input  logic          CapEn,
  input  logic          CamHsync,
  input  logic          CamVsync,
  input  logic [7:0]    CamData,
  output logic          PixValid,
  output logic [15:0]   PixData,
  output logic [XW-1:0] PixX,
  output logic [YW-1:0] PixY,
  output logic          FrameStart,
  output logic          FrameEnd,
  output logic          Busy,
  output logic          ErrFlag,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t          r_state, w_next;
  logic            r_hs, r_vs, r_hs_d, r_vs_d;
  logic [7:0]      r_data, r_hi;
  logic            r_phase, r_line_pix;
  logic [XW-1:0]   r_xcnt;
  logic [YW-1:0]   r_ycnt;
  logic            w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
  logic            w_start, w_end, w_cap, w_phase, w_pair;
  logic            w_x_full, w_y_full, w_emit;

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_data <= 8'd0;
    end else begin
      r_hs   <= CamHsync;
      r_vs   <= CamVsync;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_data <= CamData;
    end
  end

  assign w_hs_rise = r_hs & ~r_hs_d;
  assign w_hs_fall = ~r_hs & r_hs_d;
  assign w_vs_rise = r_vs & ~r_vs_d;
  assign w_vs_fall = ~r_vs & r_vs_d;

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_SYNC;
    else        r_state <= w_next;
  end

  // SYNC waits for a full vertical sync so capture never begins mid-frame.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_end   = 1'b0;
    case (r_state)
      ST_SYNC:    if (r_vs) w_next = ST_WAIT;
      ST_WAIT:    if (w_vs_fall && CapEn) begin
                    w_next  = ST_CAPTURE;
                    w_start = 1'b1;
                  end
      ST_CAPTURE: if (w_vs_rise) begin
                    w_next = ST_WAIT;
                    w_end  = 1'b1;
                  end
      default:    w_next = ST_SYNC;
    endcase
  end

  assign w_cap    = (r_state == ST_CAPTURE);
  assign w_phase  = w_hs_rise ? 1'b0 : r_phase;
  assign w_pair   = w_cap && r_hs && w_phase;
  assign w_x_full = (r_xcnt == XW'(MAX_W));
  assign w_y_full = (r_ycnt == YW'(MAX_H));
`ifdef CAM_CAPTURE_DECIM_EN
  assign w_emit   = w_pair && !w_x_full && !w_y_full && !r_xcnt[0] && !r_ycnt[0];
`else
  assign w_emit   = w_pair && !w_x_full && !w_y_full;
`endif

  assign Busy        = w_cap;
  assign o_dbg_state = r_state;

  // PixValid is a one-cycle strobe with no back-pressure; data/coords hold otherwise.
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      PixValid   <= 1'b0;
      PixData    <= 16'd0;
      PixX       <= '0;
      PixY       <= '0;
      FrameStart <= 1'b0;
      FrameEnd   <= 1'b0;
      ErrFlag    <= 1'b0;
      r_hi       <= 8'd0;
      r_phase    <= 1'b0;
      r_line_pix <= 1'b0;
      r_xcnt     <= '0;
      r_ycnt     <= '0;
    end else begin
      PixValid   <= w_emit;
      FrameStart <= w_start;
      FrameEnd   <= w_end;
      if (!w_cap)     r_phase <= 1'b0;
      else if (r_hs)  r_phase <= ~w_phase;
      if (w_cap && r_hs && !w_phase) r_hi <= r_data;
      if (w_emit) begin
        PixData <= {r_hi, r_data};
`ifdef CAM_CAPTURE_DECIM_EN
        PixX    <= {1'b0, r_xcnt[XW-1:1]};
        PixY    <= {1'b0, r_ycnt[YW-1:1]};
`else
        PixX    <= r_xcnt;
        PixY    <= r_ycnt;
`endif
      end
      if (w_hs_rise)                r_xcnt <= '0;
      else if (w_pair && !w_x_full) r_xcnt <= r_xcnt + XW'(1);
      if (w_hs_rise)   r_line_pix <= 1'b0;
      else if (w_pair) r_line_pix <= 1'b1;
      if (w_start)
        r_ycnt <= '0;
      else if (w_cap && w_hs_fall && r_line_pix && !w_y_full)
        r_ycnt <= r_ycnt + YW'(1);
      // Overflowing either limit or ending a line on a dangling byte is sticky until next frame.
      if (w_start)
        ErrFlag <= 1'b0;
      else if (w_cap && ((w_pair && (w_x_full || w_y_full)) || (w_hs_fall && r_phase)))
        ErrFlag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_capture_rx.sv
// Bench for cam_capture_rx (default build, small MAX_W/MAX_H): frame table plus
// hand sequences for latency, reset mid-frame, CapEn drop and Vsync-rise corners.
module tb_cam_capture_rx;

  localparam int TW = 6;
  localparam int TH = 5;

  logic        PCLK, RST_N, CapEn, CamHsync, CamVsync;
  logic [7:0]  CamData;
  logic        PixValid, FrameStart, FrameEnd, Busy, ErrFlag;
  logic [15:0] PixData;
  logic [10:0] PixX;
  logic [9:0]  PixY;
  logic [1:0]  dbg_state;

  cam_capture_rx #(.XW(11), .YW(10), .MAX_W(TW), .MAX_H(TH)) dut (
    .PCLK(PCLK), .RST_N(RST_N), .CapEn(CapEn), .CamHsync(CamHsync),
    .CamVsync(CamVsync), .CamData(CamData), .PixValid(PixValid),
    .PixData(PixData), .PixX(PixX), .PixY(PixY), .FrameStart(FrameStart),
    .FrameEnd(FrameEnd), .Busy(Busy), .ErrFlag(ErrFlag), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // monitor: records every observed pixel and frame pulse
  logic [36:0] got_mem [0:4095];
  int got_n = 0;
  int fs_n  = 0;
  int fe_n  = 0;
  always @(negedge PCLK) begin
    if (PixValid) begin
      if (got_n < 4096) got_mem[got_n] = {PixData, PixX, PixY};
      got_n = got_n + 1;
    end
    if (FrameStart) fs_n = fs_n + 1;
    if (FrameEnd)   fe_n = fe_n + 1;
  end

  // scoreboard
  logic [36:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rd_n   = 0;
  int s_pix, s_fs, s_fe;

  typedef struct {
    int n_lines;
    int n_bytes;
    bit cap;
    int exp_pix;
    int exp_fs;
    int exp_fe;
    bit exp_err;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int l, input int j);
    return 8'((l * 37 + j * 11 + 5) & 255);
  endfunction

  // driver tasks: inputs change at negedge, DUT samples at following posedge
  task automatic step(input logic hs, input logic vs, input logic [7:0] d);
    CamHsync = hs;
    CamVsync = vs;
    CamData  = d;
    @(negedge PCLK);
  endtask

  task automatic drive_line(input int l, input int nb);
    for (int j = 0; j < nb; j++) step(1'b1, 1'b0, pat(l, j));
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic expect_lines(input int nl, input int nb);
    for (int l = 0; l < nl; l++)
      for (int p = 0; p < nb / 2; p++)
        if (l < TH && p < TW)
          exp_q.push_back({pat(l, 2 * p), pat(l, 2 * p + 1), 11'(p), 10'(l)});
  endtask

  task automatic snap();
    s_pix = got_n;
    s_fs  = fs_n;
    s_fe  = fe_n;
  endtask

  task automatic drain(input string tag);
    logic [36:0] e;
    while (rd_n < got_n) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s extra pixel got %0h exp none", tag, got_mem[rd_n]);
      end else begin
        e = exp_q.pop_front();
        chk({tag, " pixel"}, 64'(got_mem[rd_n]), 64'(e));
      end
      rd_n = rd_n + 1;
    end
    chk({tag, " missing"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    snap();
    CapEn = v.cap;
    if (v.cap) expect_lines(v.n_lines, v.n_bytes);
    repeat (2) step(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < v.n_lines; l++) begin
      drive_line(l, v.n_bytes);
      if (l == 0) chk({tag, " busy"}, 64'(Busy), 64'(v.cap));
    end
    repeat (4) step(1'b0, 1'b1, 8'h00);
    chk({tag, " pix count"}, 64'(got_n - s_pix), 64'(v.exp_pix));
    chk({tag, " fs count"}, 64'(fs_n - s_fs), 64'(v.exp_fs));
    chk({tag, " fe count"}, 64'(fe_n - s_fe), 64'(v.exp_fe));
    chk({tag, " err"}, 64'(ErrFlag), 64'(v.exp_err));
    drain(tag);
  endtask

  initial begin
    vec_t vr;
    vecs[0] = '{3, 12, 1'b1, 18, 1, 1, 1'b0};  // full-width lines
    vecs[1] = '{2, 4,  1'b1, 4,  1, 1, 1'b0};
    vecs[2] = '{2, 13, 1'b1, 12, 1, 1, 1'b1};  // odd byte count
    vecs[3] = '{2, 5,  1'b1, 4,  1, 1, 1'b1};
    vecs[4] = '{7, 4,  1'b1, 10, 1, 1, 1'b1};  // more lines than TH
    vecs[5] = '{3, 8,  1'b0, 0,  0, 0, 1'b1};  // ignored, error stays sticky
    vecs[6] = '{1, 2,  1'b1, 1,  1, 1, 1'b0};  // error cleared at FrameStart
    vecs[7] = '{2, 14, 1'b1, 12, 1, 1, 1'b1};  // more pixels than TW

    RST_N = 1'b0; CapEn = 1'b0; CamHsync = 1'b0; CamVsync = 1'b0; CamData = 8'h00;
    repeat (3) @(negedge PCLK);
    chk("rst PixValid", 64'(PixValid), 64'd0);
    chk("rst PixData", 64'(PixData), 64'd0);
    chk("rst PixX", 64'(PixX), 64'd0);
    chk("rst PixY", 64'(PixY), 64'd0);
    chk("rst FrameStart", 64'(FrameStart), 64'd0);
    chk("rst FrameEnd", 64'(FrameEnd), 64'd0);
    chk("rst Busy", 64'(Busy), 64'd0);
    chk("rst ErrFlag", 64'(ErrFlag), 64'd0);
    chk("rst state", 64'(dbg_state), 64'd0);
    RST_N = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    repeat (4) step(1'b0, 1'b1, 8'h00);
    chk("wait state", 64'(dbg_state), 64'd1);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // latency: 0x12,0x34 -> 16'h1234 one edge after the low byte is registered
    CapEn = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00);
    snap();
    exp_q.push_back({16'h1234, 11'd0, 10'd0});
    step(1'b1, 1'b0, 8'h12);
    step(1'b1, 1'b0, 8'h34);
    chk("lat early", 64'(PixValid), 64'd0);
    step(1'b0, 1'b0, 8'h00);
    chk("lat valid", 64'(PixValid), 64'd1);
    chk("lat data", 64'(PixData), 64'h1234);
    step(1'b0, 1'b0, 8'h00);
    chk("lat hold", 64'(PixData), 64'h1234);
    chk("lat strobe", 64'(PixValid), 64'd0);
    repeat (4) step(1'b0, 1'b1, 8'h00);
    drain("lat");

    // reset in the middle of a frame
    repeat (2) step(1'b0, 1'b0, 8'h00);
    expect_lines(1, 4);
    drive_line(0, 4);
    RST_N = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    chk("mid rst state", 64'(dbg_state), 64'd0);
    RST_N = 1'b1;
    snap();
    drive_line(1, 4);
    drive_line(2, 4);
    chk("post rst no pix", 64'(got_n - s_pix), 64'd0);
    chk("post rst sync", 64'(dbg_state), 64'd0);
    repeat (4) step(1'b0, 1'b1, 8'h00);
    chk("post rst no fe", 64'(fe_n - s_fe), 64'd0);
    chk("post rst wait", 64'(dbg_state), 64'd1);
    drain("rst");
    vr = '{2, 4, 1'b1, 4, 1, 1, 1'b0};
    run_frame(vr, "after rst");

    // CapEn dropped mid-frame: frame completes, next frame ignored
    CapEn = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00);
    snap();
    expect_lines(3, 4);
    drive_line(0, 4);
    CapEn = 1'b0;
    drive_line(1, 4);
    drive_line(2, 4);
    repeat (4) step(1'b0, 1'b1, 8'h00);
    chk("capen pix", 64'(got_n - s_pix), 64'd6);
    chk("capen fe", 64'(fe_n - s_fe), 64'd1);
    drain("capen");
    vr = '{2, 4, 1'b0, 0, 0, 0, 1'b0};
    run_frame(vr, "capen off");

    // Vsync rise together with the last low byte: pixel and FrameEnd together
    CapEn = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00);
    snap();
    exp_q.push_back({16'hA1B2, 11'd0, 10'd0});
    exp_q.push_back({16'hC3D4, 11'd1, 10'd0});
    step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 8'hB2);
    step(1'b1, 1'b0, 8'hC3);
    step(1'b1, 1'b1, 8'hD4);
    step(1'b0, 1'b1, 8'h00);
    chk("same valid", 64'(PixValid), 64'd1);
    chk("same fe", 64'(FrameEnd), 64'd1);
    chk("same data", 64'(PixData), 64'hC3D4);
    chk("same x", 64'(PixX), 64'd1);
    repeat (3) step(1'b0, 1'b1, 8'h00);
    chk("same fe count", 64'(fe_n - s_fe), 64'd1);
    drain("same");

    // Vsync rise with a half pair pending: partial pixel dropped
    repeat (2) step(1'b0, 1'b0, 8'h00);
    snap();
    exp_q.push_back({16'hA1B2, 11'd0, 10'd0});
    step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 8'hB2);
    step(1'b1, 1'b1, 8'hC3);
    step(1'b1, 1'b1, 8'hD4);
    repeat (4) step(1'b0, 1'b1, 8'h00);
    chk("abort pix", 64'(got_n - s_pix), 64'd1);
    chk("abort fe", 64'(fe_n - s_fe), 64'd1);
    chk("abort err", 64'(ErrFlag), 64'd0);
    chk("abort state", 64'(dbg_state), 64'd1);
    drain("abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
